// File: rtl/load_align_unit.sv
// Load alignment unit: fetches one or two memory words for a byte/half/word load,
// then shifts and sign/zero-extends the result. Misaligned split support: `LOAD_ALIGN_MISALIGN_EN.
//
// state | meaning
// IDLE  | ready for a request
// REQ0  | first word read request outstanding
// WAIT0 | waiting for first word
// REQ1  | second word read request outstanding (split loads only)
// WAIT1 | waiting for second word
// RESP  | result held until consumer takes it
module load_align_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_func3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t              state_q;
  logic                req_ready_q;
  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   mem_req_addr_q;
  logic                rsp_valid_q;
  logic                rsp_fault_q;
  logic [2:0]          func3_q;
  logic [1:0]          off_q;
  logic [DATA_W-1:0]   beat0_q;
  logic [DATA_W-1:0]   beat1_q;

  logic                req_legal;
  logic                req_misaligned;
  logic                req_fault;
  logic                spans_two;

  function automatic logic [DATA_W-1:0] merge_beats(
    input logic [DATA_W-1:0] b1,
    input logic [DATA_W-1:0] b0,
    input logic [1:0]        off,
    input logic [2:0]        f3
  );
    logic [2*DATA_W-1:0] pair;
    logic [DATA_W-1:0]   lane;
    logic [DATA_W-1:0]   res;
    pair = {b1, b0};
    lane = DATA_W'(pair >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   res = f3[2] ? {{(DATA_W-8){1'b0}}, lane[7:0]}
                           : {{(DATA_W-8){lane[7]}}, lane[7:0]};
      2'b01:   res = f3[2] ? {{(DATA_W-16){1'b0}}, lane[15:0]}
                           : {{(DATA_W-16){lane[15]}}, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  always_comb begin
    req_legal = 1'b0;
    case (req_func3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
      default:                                req_legal = 1'b0;
    endcase
    req_misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LOAD_ALIGN_MISALIGN_EN
    req_fault = !req_legal;
    spans_two = ((func3_q[1:0] == 2'b01) && (off_q == 2'b11)) ||
                ((func3_q[1:0] == 2'b10) && (off_q != 2'b00));
`else
    req_fault = !req_legal || req_misaligned;
    spans_two = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_fault_q     <= 1'b0;
      func3_q         <= 3'b000;
      off_q           <= 2'b00;
      beat0_q         <= '0;
      beat1_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            func3_q     <= req_func3;
            off_q       <= req_addr[1:0];
            beat0_q     <= '0;
            beat1_q     <= '0;
            if (req_fault) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
            end else begin
              state_q         <= REQ0;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        REQ0: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rsp_valid) begin
            beat0_q <= mem_rsp_data;
            if (spans_two) begin
              state_q         <= REQ1;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= mem_req_addr_q + ADDR_W'(4);
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b0;
            end
          end
        end
        REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rsp_valid) begin
            beat1_q     <= mem_rsp_data;
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b0;
          end
        end
        RESP: begin
          // req_ready rises only after this edge, so no back-to-back accept
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q         <= IDLE;
          req_ready_q     <= 1'b1;
          mem_req_valid_q <= 1'b0;
          rsp_valid_q     <= 1'b0;
          rsp_fault_q     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_fault     = rsp_fault_q;
  // Result is a pure function of the captured beats; forced to zero unless a good response is held.
  assign rsp_data      = (rsp_valid_q && !rsp_fault_q)
                         ? merge_beats(beat1_q, beat0_q, off_q, func3_q) : '0;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit; expectations follow LOAD_ALIGN_MISALIGN_EN when defined.
module tb_load_align_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_func3;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  int checks = 0;
  int errors = 0;

  load_align_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_func3     (req_func3),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_fault     (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one load against a zero-wait memory that returns w0 for the first beat and w1 for the second.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] w0, input logic [31:0] w1, input int hold,
                         input logic [31:0] exp_d, input logic exp_f, input int exp_lat,
                         input int exp_nb, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    int          lat;
    int          nb;
    logic        pend;
    logic [31:0] d;
    logic        flt;
    logic [31:0] ba0;
    logic [31:0] ba1;
    lat = -1; nb = 0; pend = 1'b0; d = '0; flt = 1'b0; ba0 = '0; ba1 = '0;
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_func3 = f3;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      if (pend) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = (nb == 1) ? w0 : w1;
        pend = 1'b0;
      end
      if (rsp_valid) begin
        lat = c; d = rsp_data; flt = rsp_fault;
      end else if (mem_req_valid) begin
        if (nb == 0) ba0 = mem_req_addr;
        else         ba1 = mem_req_addr;
        nb++;
        pend = 1'b1;
      end
    end
    mem_rsp_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"},    d, exp_d);
    chk({tag, "_fault"},   32'(flt), 32'(exp_f));
    chk({tag, "_beats"},   32'(nb), 32'(exp_nb));
    if (exp_nb > 0) chk({tag, "_addr0"}, ba0, exp_a0);
    if (exp_nb > 1) chk({tag, "_addr1"}, ba1, exp_a1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_data"},  rsp_data, exp_d);
      chk({tag, "_hold_fault"}, 32'(rsp_fault), 32'(exp_f));
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_hold_memreq"}, 32'(mem_req_valid), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_func3 = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    rst_n = 1'b1;

    do_load("lb_100",  32'h100, 3'b000, 32'h0000_00F0, 32'h0, 0, 32'hFFFF_FFF0, 1'b0, 3, 1, 32'h100, 32'h0);
    do_load("lhu_102", 32'h102, 3'b101, 32'h8001_ABCD, 32'h0, 0, 32'h0000_8001, 1'b0, 3, 1, 32'h100, 32'h0);
    do_load("lh_102",  32'h102, 3'b001, 32'h8001_ABCD, 32'h0, 0, 32'hFFFF_8001, 1'b0, 3, 1, 32'h100, 32'h0);
    do_load("lbu_101", 32'h101, 3'b100, 32'h1234_8056, 32'h0, 0, 32'h0000_0080, 1'b0, 3, 1, 32'h100, 32'h0);
    do_load("lw_200",  32'h200, 3'b010, 32'hDEAD_BEEF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 3, 1, 32'h200, 32'h0);
    do_load("lb_203",  32'h203, 3'b000, 32'h7F00_0000, 32'h0, 0, 32'h0000_007F, 1'b0, 3, 1, 32'h200, 32'h0);
`ifdef LOAD_ALIGN_MISALIGN_EN
    do_load("lw_103",  32'h103, 3'b010, 32'h1122_3344, 32'h5566_7788, 0, 32'h6677_8811, 1'b0, 5, 2, 32'h100, 32'h104);
    do_load("lh_101",  32'h101, 3'b001, 32'h12AB_CD34, 32'h0, 0, 32'hFFFF_ABCD, 1'b0, 3, 1, 32'h100, 32'h0);
    do_load("lhu_103", 32'h103, 3'b101, 32'hAB00_0000, 32'h0000_00CD, 0, 32'h0000_CDAB, 1'b0, 5, 2, 32'h100, 32'h104);
    do_load("lw_wrap", 32'hFFFF_FFFE, 3'b010, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 0, 32'hDDDD_AAAA, 1'b0, 5, 2, 32'hFFFF_FFFC, 32'h0);
`else
    do_load("lw_103",  32'h103, 3'b010, 32'h1122_3344, 32'h5566_7788, 0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    do_load("lh_101",  32'h101, 3'b001, 32'h12AB_CD34, 32'h0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    do_load("lhu_103", 32'h103, 3'b101, 32'hAB00_0000, 32'h0000_00CD, 0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    do_load("lw_wrap", 32'hFFFF_FFFE, 3'b010, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
`endif
    do_load("f3_011",  32'h100, 3'b011, 32'h1234_5678, 32'h0, 4, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);

    // Stalled request, then reset while waiting for the first word.
    @(negedge clk);
    mem_req_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h200; req_func3 = 3'b010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
      chk("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_mem_req_addr", mem_req_addr, 32'h200);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("wait0_mem_req_valid", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_rsp_fault", 32'(rsp_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
    end

    do_load("lb_after_rst", 32'h100, 3'b000, 32'h0000_00F0, 32'h0, 0, 32'hFFFF_FFF0, 1'b0, 3, 1, 32'h100, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
- REQ-001: Parameter ADDR_W, default 32, width of the load address and the memory address.
- REQ-002: Parameter DATA_W, default 32, width of the memory word and the result; legal value 32 only.
- REQ-003: clk  input  1  the single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous and active-low.
- REQ-005: req_valid  input  1  load request present.
- REQ-006: req_ready  output  1  unit accepts a request.
- REQ-007: req_addr  input  ADDR_W  byte address of the load.
- REQ-008: req_func3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- REQ-009: mem_req_valid  output  1  memory read request.
- REQ-010: mem_req_ready  input  1  memory accepts the read request.
- REQ-011: mem_req_addr  output  ADDR_W  word-aligned read address, with bits [1:0] equal to 00.
- REQ-012: mem_rsp_valid  input  1  read data returned.
- REQ-013: mem_rsp_data  input  DATA_W  returned memory word.
- REQ-014: rsp_valid  output  1  load result available.
- REQ-015: rsp_ready  input  1  consumer takes the result.
- REQ-016: rsp_data  output  DATA_W  extended load result.
- REQ-017: rsp_fault  output  1  the load is faulted; valid while rsp_valid is 1.

Function
- REQ-018: The state machine SHALL have the states IDLE, REQ0, WAIT0, REQ1, WAIT1 and RESP.
- REQ-019: req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on req_valid && req_ready, which latches addr, func3 and off = addr[1:0].
- REQ-020: Illegal func3, or a misaligned load that is not supported, SHALL move IDLE -> RESP with rsp_fault=1 and rsp_data=0, and SHALL issue no memory request.
- REQ-021: Otherwise the unit SHALL move IDLE -> REQ0, drive mem_req_valid=1 with mem_req_addr={addr[ADDR_W-1:2],2'b00}, and hold both until mem_req_ready.
- REQ-022: In WAIT0, mem_rsp_valid SHALL capture beat0; the unit then moves to REQ1 if the load spans two words, else to RESP.
- REQ-023: A load spans two words when it is lh/lhu with off=3, or lw with off != 0.
- REQ-024: REQ1 and WAIT1 SHALL behave as REQ0 and WAIT0, using address word+4 (modulo 2^ADDR_W, so all-ones wraps to 0) and capturing beat1.
- REQ-025: The merged value SHALL be ({beat1,beat0} >> 8*off) truncated to the access size; beat1 is 0 for single-word loads.
- REQ-026: Signed types SHALL sign-extend from bit 7 or bit 15, and unsigned types SHALL zero-extend.
- REQ-027: In RESP, rsp_valid=1, and rsp_data and rsp_fault SHALL be stable until rsp_ready, after which the unit returns to IDLE.
- REQ-028: A new request SHALL NOT be accepted in the same cycle that a response completes.
- REQ-029: The minimum aligned latency from acceptance to rsp_valid SHALL be 3 cycles with zero-wait memory, and the split latency 5 cycles.
- REQ-030: mem_rsp_valid outside WAIT0 and WAIT1 SHALL be ignored.

Reset
- REQ-031: Assertion of rst_n=0 SHALL immediately force state IDLE, req_ready=1, mem_req_valid=0, rsp_valid=0, rsp_data=0, rsp_fault=0, and clear the captured beats.
- REQ-032: Reset in the middle of a transaction SHALL abandon it; the unit SHALL issue no further beat and produce no response.

Configuration
- REQ-033: Macro LOAD_ALIGN_MISALIGN_EN SHALL control misaligned-load support.
- REQ-034: With the macro defined, misaligned loads SHALL be handled by the two-beat split of REQ-022..REQ-025.
- REQ-035: Without the macro, lh/lhu with off odd, and lw with off != 0, SHALL fault per REQ-020; aligned behaviour SHALL be unchanged and REQ1/WAIT1 are unreachable.

Verification
- REQ-036: Request lb at 0x100 with word 0x000000F0 -> one beat, rsp_data=0xFFFFFFF0, fault=0, rsp_valid 3 cycles after acceptance.
- REQ-037: Request lhu at 0x102 with word 0x8001ABCD -> rsp_data=0x00008001; request lh at the same address -> 0xFFFF8001.
- REQ-038: With the macro, lw at 0x103, word@0x100=0x11223344 and word@0x104=0x55667788 -> beats to 0x100 then 0x104, rsp_data=0x66778811; without the macro -> fault=1, data=0, no memory request.
- REQ-039: Request func3=011 -> fault=1, rsp_data=0, mem_req_valid never asserted; rsp_ready held at 0 for 4 cycles -> outputs stable, req_ready=0.
- REQ-040: Request lw at 0x200 with mem_req_ready low for 3 cycles, then reset asserted in WAIT0 -> all outputs at reset values, and a later mem_rsp_valid is ignored.
- REQ-041: With the macro, lw at 0xFFFFFFFE -> second beat address 0x00000000.
